// File: rtl/filter_sel_pkg.sv
// Shared state type and mode helpers for the frame-synchronous filter output selector.
package filter_sel_pkg;

    localparam int unsigned MAX_FLT = 32;

    typedef enum logic [1:0] {
        PASS,
        ARM,
        MUTE
    } state_e;

    // Mode k enables filter k-1; mode 0 (bypass) enables nothing.
    function automatic logic [MAX_FLT-1:0] onehot_en(input int unsigned m);
        logic [MAX_FLT:0] v;
        v = {{MAX_FLT{1'b0}}, 1'b1} << m;
        return v[MAX_FLT:1];
    endfunction

    function automatic int unsigned clamp_mode(input int unsigned m, input int unsigned n_flt);
        return (m > n_flt) ? 32'd0 : m;
    endfunction

endpackage

// File: rtl/video_delay.sv
// LAT-deep vs/de/data shift register for latency matching; plain wires when LAT is 0.
module video_delay #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned LAT    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vs,
    input  logic              in_de,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vs,
    output logic              out_de,
    output logic [DATA_W-1:0] out_data
);

    if (LAT == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = ^{clk, rst_n};
        assign out_vs   = in_vs;
        assign out_de   = in_de;
        assign out_data = in_data;
    end else begin : g_pipe
        logic [DATA_W+1:0] sr [LAT];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < LAT; i++) sr[i] <= '0;
            end else begin
                sr[0] <= {in_vs, in_de, in_data};
                for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
            end
        end

        assign out_vs   = sr[LAT-1][DATA_W+1];
        assign out_de   = sr[LAT-1][DATA_W];
        assign out_data = sr[LAT-1][DATA_W-1:0];
    end

endmodule

// File: rtl/filter_sel.sv
// Selects bypass or one of N_FLT filter streams, switching only at frame starts and
// muting the output while the newly enabled filter refills its line buffers.
module filter_sel
    import filter_sel_pkg::*;
#(
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned N_FLT       = 3,
    parameter int unsigned MODE_W      = 2,
    parameter int unsigned BYPASS_LAT  = 0,
    parameter int unsigned MUTE_FRAMES = 1,
    parameter int unsigned RESET_MODE  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [MODE_W-1:0]       mode,
    input  logic                    pre_vs,
    input  logic                    pre_de,
    input  logic [DATA_W-1:0]       pre_data,
    input  logic [N_FLT-1:0]        flt_vs,
    input  logic [N_FLT-1:0]        flt_de,
    input  logic [N_FLT*DATA_W-1:0] flt_data,
    output logic [N_FLT-1:0]        flt_en,
    output logic                    post_vs,
    output logic                    post_de,
    output logic [DATA_W-1:0]       post_data,
    output logic [MODE_W-1:0]       cur_mode,
    output logic                    busy
);

    localparam int unsigned N_PATH = 1 << MODE_W;
    localparam int unsigned CNT_W  = (MUTE_FRAMES == 0) ? 1 : $clog2(MUTE_FRAMES + 1);
    localparam logic [N_FLT-1:0] RST_EN = N_FLT'(onehot_en(RESET_MODE));

    logic              byp_vs;
    logic              byp_de;
    logic [DATA_W-1:0] byp_data;

    logic [N_PATH-1:0] p_vs;
    logic [N_PATH-1:0] p_de;
    logic [DATA_W-1:0] p_data [N_PATH];
    logic [N_PATH-1:0] vs_q;
    logic [N_PATH-1:0] fs;

    logic [MODE_W-1:0] req;
    logic [N_FLT-1:0]  req_en;
    state_e            state;
    logic [MODE_W-1:0] tgt;
    logic [CNT_W-1:0]  cnt;

    video_delay #(
        .DATA_W (DATA_W),
        .LAT    (BYPASS_LAT)
    ) u_bypass (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vs    (pre_vs),
        .in_de    (pre_de),
        .in_data  (pre_data),
        .out_vs   (byp_vs),
        .out_de   (byp_de),
        .out_data (byp_data)
    );

    // Path table indexed directly by mode; slots beyond N_FLT are tied off.
    assign p_vs[0]   = byp_vs;
    assign p_de[0]   = byp_de;
    assign p_data[0] = byp_data;

    for (genvar i = 1; i < N_PATH; i++) begin : g_path
        if (i <= N_FLT) begin : g_flt
            assign p_vs[i]   = flt_vs[i-1];
            assign p_de[i]   = flt_de[i-1];
            assign p_data[i] = flt_data[(i-1)*DATA_W +: DATA_W];
        end else begin : g_tie
            assign p_vs[i]   = 1'b0;
            assign p_de[i]   = 1'b0;
            assign p_data[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vs_q <= '0;
        else        vs_q <= p_vs;
    end

    assign fs     = p_vs & ~vs_q;
    assign req    = MODE_W'(clamp_mode(32'(mode), N_FLT));
    assign req_en = N_FLT'(onehot_en(32'(req)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PASS;
            cur_mode  <= MODE_W'(RESET_MODE);
            tgt       <= MODE_W'(RESET_MODE);
            cnt       <= '0;
            post_vs   <= 1'b0;
            post_de   <= 1'b0;
            post_data <= '0;
            flt_en    <= RST_EN;
            busy      <= 1'b0;
        end else begin
            post_vs   <= 1'b0;
            post_de   <= 1'b0;
            post_data <= '0;
            case (state)
                PASS: begin
                    post_vs   <= p_vs[cur_mode];
                    post_de   <= p_de[cur_mode];
                    post_data <= p_data[cur_mode];
                    if (req != cur_mode) begin
                        tgt   <= req;
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (req == cur_mode) begin
                        post_vs   <= p_vs[cur_mode];
                        post_de   <= p_de[cur_mode];
                        post_data <= p_data[cur_mode];
                        state     <= PASS;
                        busy      <= 1'b0;
                    end else if (fs[cur_mode]) begin
                        // Muting starts on the current path's frame start itself.
                        tgt    <= req;
                        cnt    <= '0;
                        flt_en <= req_en;
                        state  <= MUTE;
                    end else begin
                        post_vs   <= p_vs[cur_mode];
                        post_de   <= p_de[cur_mode];
                        post_data <= p_data[cur_mode];
                        tgt       <= req;
                    end
                end
                MUTE: begin
                    if (req != tgt) begin
                        tgt    <= req;
                        cnt    <= '0;
                        flt_en <= req_en;
                    end else if (fs[tgt]) begin
                        if (cnt == CNT_W'(MUTE_FRAMES)) begin
                            // Forward this cycle so the first committed frame is whole.
                            post_vs   <= p_vs[tgt];
                            post_de   <= p_de[tgt];
                            post_data <= p_data[tgt];
                            cur_mode  <= tgt;
                            state     <= PASS;
                            busy      <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

endmodule

// File: doc/filter_sel.md
# filter_sel

Frame-synchronous output selector for the DVP video-processing chain. It chooses between a delay-matched bypass of the raw stream and N_FLT parallel filter paths, such as gaussian, median and mean. A mode change takes effect only at a frame boundary, so frames are never cut mid-stream. The block drives the per-filter enables and blanks the output while a newly enabled filter's line buffers refill.

## Interface
Parameters:
- DATA_W, 24, pixel width
- N_FLT, 3, number of filter paths; mode k selects filter k-1, mode 0 selects bypass
- MODE_W, 2, mode input width; 2^MODE_W >= N_FLT+1 required
- BYPASS_LAT, 0, extra register stages on the bypass path (0 allowed)
- MUTE_FRAMES, 1, target-path frames discarded after a switch (0 allowed)
- RESET_MODE, 0, mode active after reset

Ports:
- clk  in  1  video pixel clock; the block has one clock
- rst_n  in  1  reset, asynchronous, active-low
- mode  in  MODE_W  requested mode; values > N_FLT are treated as 0
- pre_vs / pre_de  in  1  raw stream frame sync (active high) / data enable
- pre_data  in  DATA_W  raw pixel
- flt_vs / flt_de  in  N_FLT  per-filter output vs / de
- flt_data  in  N_FLT*DATA_W  per-filter pixels; filter i occupies bits [i*DATA_W +: DATA_W]
- flt_en  out  N_FLT  per-filter enable
- post_vs / post_de  out  1  selected vs / de, registered
- post_data  out  DATA_W  selected pixel, registered
- cur_mode  out  MODE_W  committed mode
- busy  out  1  a switch is in progress

## Operation
- Path 0 is pre_* through BYPASS_LAT stages. Path k (k ≥ 1) is flt_*[k-1].
- Each path's vs is registered once for rising-edge detection. A frame start is vs=1 with previous vs=0.
- req = mode, clamped to 0 when mode > N_FLT.
- State PASS:
  - Output follows path cur.
  - If req != cur: tgt <= req, go to ARM.
- State ARM:
  - Output still follows cur.
  - If req == cur: return to PASS.
  - Else if req != tgt: tgt <= req.
  - On a frame start of path cur: cnt <= 0, go to MUTE. That cycle is already muted.
- State MUTE:
  - post_vs, post_de and post_data are forced to 0.
  - If req != tgt: tgt <= req and cnt <= 0. This includes req == cur, which re-enters cur via a full mute.
  - On a frame start of path tgt with cnt == MUTE_FRAMES: cur <= tgt, go to PASS. That cycle's tgt inputs are forwarded, so the first output frame is complete.
  - On a frame start of path tgt with cnt < MUTE_FRAMES: cnt++.
- flt_en:
  - PASS and ARM: one-hot of cur. All zeros when cur = 0.
  - MUTE: one-hot of tgt only.
- busy = (state != PASS).
- cnt width is clog2(MUTE_FRAMES+1), minimum 1 bit.
- A path with vs stuck low keeps the block in MUTE indefinitely. A later mode change re-targets it. No timeout is implemented.

## Timing
- Reset values:
  - state PASS, cur = tgt = RESET_MODE, cnt 0
  - post_vs, post_de, post_data = 0
  - flt_en = one-hot(RESET_MODE), busy 0, cur_mode = RESET_MODE
  - bypass delay stages and vs history cleared
- Latency:
  - filter path to post_*: 1 cycle
  - pre_* to post_* in bypass: BYPASS_LAT+1 cycles
- mode is sampled every cycle. A change that is reverted before ARM exits is a no-op.
- flt_en changes on the ARM→MUTE transition edge.
- cur_mode and busy update on the PASS transition edge, in the same cycle the first new vs is registered to post_vs.
- Simultaneous events:
  - ARM frame start of cur together with req == cur: return to PASS, no mute.
  - MUTE frame start of tgt together with a req change: the req change wins; restart with cnt = 0, no commit.
- Asserting rst_n low mid-switch returns the block to RESET_MODE immediately.

## Structure
- Package filter_sel_pkg holds:
  - the state enum (PASS, ARM, MUTE)
  - a onehot_en function mapping a mode to an N_FLT enable vector with bit 0 dropped
  - the clamp function
- Sub-module video_delay: a BYPASS_LAT-deep vs/de/data shift register with async reset, which degenerates to wires at 0. It is reusable wherever the team needs latency matching.

## Test plan
- Reset with RESET_MODE=0, BYPASS_LAT=2: post_* = 0 during reset. After release, a 4×2 frame on pre_* appears on post_* 3 cycles later; flt_en=000.
- In PASS mode 0, set mode=2 mid-frame with MUTE_FRAMES=1:
  - The current frame completes unchanged.
  - At the next pre_vs rise the output is muted and flt_en=010.
  - flt[1] frame 1 is dropped.
  - At flt[1] frame 2 vs rise, post_vs rises 1 cycle later, cur_mode=2 and busy drops.
- mode=3 then back to 0 before the next frame start: state returns to PASS, no muted cycle, flt_en unchanged.
- In MUTE toward 2, change mode to 1: flt_en becomes 001, cnt restarts, and commit happens to mode 1 after MUTE_FRAMES+1 flt[0] frames.
- mode=3 with N_FLT=2 is clamped to 0: no switch from bypass, busy stays 0.
- Assert rst_n mid-MUTE: all outputs go to reset values asynchronously. After release the block is in PASS on RESET_MODE.
